// File: rtl/bitwise_serial.sv
// Slice-serial bitwise unit: applies AND/OR/XOR/AND-NOT to WIDTH-bit operands
// CHUNK bits per clock, LSB slice first, with a start/busy/done handshake.
module bitwise_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op_sel,
  input  logic             a_sel,
  input  logic [1:0]       b_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   real_a;
  logic [WIDTH-1:0]   real_b;
  op_t                op;

  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  int unsigned        base;
  logic [CHUNK-1:0]   slice_a;
  logic [CHUNK-1:0]   slice_b;
  logic [CHUNK-1:0]   slice_res;
  logic [WIDTH-1:0]   res_next;
  logic               last;

  // Operand selects are resolved once, at acceptance, so later input changes
  // cannot disturb a running operation.
  always_comb begin
    sel_a = a_sel ? b : a;
    unique casez (b_sel)
      2'b1?:   sel_b = '0;
      2'b01:   sel_b = '1;
      default: sel_b = b;
    endcase
  end

  // NOTE: every always_comb output gets a value on every path (defaults first)
  // so no latch is inferred.
  always_comb begin
    base    = int'(idx) * CHUNK;
    slice_a = real_a[base +: CHUNK];
    slice_b = real_b[base +: CHUNK];
    unique case (op)
      OP_AND:  slice_res = slice_a & slice_b;
      OP_OR:   slice_res = slice_a | slice_b;
      OP_XOR:  slice_res = slice_a ^ slice_b;
      default: slice_res = slice_a & ~slice_b;
    endcase
    res_next = res;
    res_next[base +: CHUNK] = slice_res;
    last = (idx == IDX_W'(NCHUNK - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      real_a <= '0;
      real_b <= '0;
      op     <= OP_AND;
      res    <= '0;
      zero   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            real_a <= sel_a;
            real_b <= sel_b;
            op     <= op_t'(op_sel);
            idx    <= '0;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          res <= res_next;
          if (last) begin
            // zero must reflect the slice written on this same edge.
            zero  <= (res_next == '0);
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
